// File: rtl/ram_pkg.sv
// Shared types and helpers for the byte-enable simple-dual-port RAM with clear sweep.
package ram_pkg;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_e;

    localparam int RDW_OLD = 0;
    localparam int RDW_NEW = 1;

    function automatic int nbytes(input int data_width);
        return data_width / 8;
    endfunction

endpackage

// File: rtl/ram_clear_seq.sv
// Clear sequencer: sweeps CLEAR_VALUE through every word after reset or on a clr pulse.
module ram_clear_seq
    import ram_pkg::*;
#(
    parameter int                    ADDR_WIDTH  = 6,
    parameter int                    DATA_WIDTH  = 8,
    parameter int                    DEPTH       = 64,
    parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clr,
    output logic                  busy,
    output logic                  ovr_en,
    output logic [ADDR_WIDTH-1:0] ovr_addr,
    output logic [DATA_WIDTH-1:0] ovr_data
);

    localparam logic [ADDR_WIDTH-1:0] LAST_PTR = ADDR_WIDTH'(DEPTH - 1);

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        case (state_q)
            ST_CLEAR: begin
                ptr_d = ptr_q + ADDR_WIDTH'(1);
                if (ptr_q == LAST_PTR) begin
                    state_d = ST_IDLE;
                    ptr_d   = '0;
                end
            end
            ST_IDLE: begin
                if (clr) begin
                    state_d = ST_CLEAR;
                    ptr_d   = '0;
                end
            end
            default: begin
                state_d = ST_CLEAR;
                ptr_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_CLEAR;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
        end
    end

    // The sweep owns the write port for its whole duration.
    assign busy     = (state_q == ST_CLEAR);
    assign ovr_en   = busy;
    assign ovr_addr = ptr_q;
    assign ovr_data = CLEAR_VALUE;

endmodule

// File: rtl/ram_sdp_be_clr.sv
// Simple-dual-port RAM with byte enables, registered read, selectable read-during-write and clear sweep.
module ram_sdp_be_clr
    import ram_pkg::*;
#(
    parameter int                    ADDR_WIDTH  = 6,
    parameter int                    DATA_WIDTH  = 8,
    parameter int                    DEPTH       = 64,
    parameter int                    RDW_MODE    = 0,
    parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE = '0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clr,
    input  logic                    wr_en,
    input  logic [ADDR_WIDTH-1:0]   wr_addr,
    input  logic [DATA_WIDTH-1:0]   wr_data,
    input  logic [DATA_WIDTH/8-1:0] wr_be,
    input  logic                    rd_en,
    input  logic [ADDR_WIDTH-1:0]   rd_addr,
    output logic [DATA_WIDTH-1:0]   rd_data,
    output logic                    rd_valid,
    output logic                    busy
);

    localparam int                  NB        = nbytes(DATA_WIDTH);
    localparam logic [ADDR_WIDTH:0] DEPTH_EXT = (ADDR_WIDTH + 1)'(DEPTH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic                  seq_busy;
    logic                  ovr_en;
    logic [ADDR_WIDTH-1:0] ovr_addr;
    logic [DATA_WIDTH-1:0] ovr_data;

    ram_clear_seq #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .CLEAR_VALUE(CLEAR_VALUE)
    ) u_clear_seq (
        .clk     (clk),
        .rst     (rst),
        .clr     (clr),
        .busy    (seq_busy),
        .ovr_en  (ovr_en),
        .ovr_addr(ovr_addr),
        .ovr_data(ovr_data)
    );

    logic                  wr_in_range;
    logic                  rd_in_range;
    logic                  wr_fire;
    logic [DATA_WIDTH-1:0] wr_merged;
    logic [ADDR_WIDTH-1:0] mem_waddr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic [NB-1:0]         mem_wbe;

    // wr_merged is only consumed when wr_addr == rd_addr, so the read word is its base.
    always_comb begin
        wr_in_range = ({1'b0, wr_addr} < DEPTH_EXT);
        rd_in_range = ({1'b0, rd_addr} < DEPTH_EXT);
        wr_fire     = wr_en && !seq_busy && wr_in_range;
        wr_merged   = '0;
        if (rd_in_range) begin
            wr_merged = mem[rd_addr];
        end
        for (int i = 0; i < NB; i++) begin
            if (wr_be[i]) begin
                wr_merged[8*i +: 8] = wr_data[8*i +: 8];
            end
        end
        mem_waddr = wr_addr;
        mem_wdata = wr_data;
        mem_wbe   = wr_fire ? wr_be : '0;
        if (ovr_en) begin
            mem_waddr = ovr_addr;
            mem_wdata = ovr_data;
            mem_wbe   = '1;
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < NB; i++) begin
            if (mem_wbe[i]) begin
                mem[mem_waddr][8*i +: 8] <= mem_wdata[8*i +: 8];
            end
        end
    end

    logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
    logic                  rd_valid_q, rd_valid_d;

    always_comb begin
        rd_valid_d = rd_en && !seq_busy;
        rd_data_d  = rd_data_q;
        if (rd_valid_d) begin
            if (!rd_in_range) begin
                rd_data_d = '0;
            end else if (RDW_MODE == RDW_NEW && wr_fire && wr_addr == rd_addr) begin
                rd_data_d = wr_merged;
            end else begin
                rd_data_d = mem[rd_addr];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    assign rd_data  = rd_data_q;
    assign rd_valid = rd_valid_q;
    assign busy     = seq_busy;

endmodule

// File: tb/tb_ram_sdp_be_clr.sv
// Bench for ram_sdp_be_clr: two 32-bit instances (64 words old-data RDW, 48 words new-data RDW) share stimulus.
module tb_ram_sdp_be_clr;

    localparam int NDUT = 2;

    logic        clk = 1'b0;
    logic        rst, clr, wr_en, rd_en;
    logic [5:0]  wr_addr, rd_addr;
    logic [31:0] wr_data;
    logic [3:0]  wr_be;

    logic [31:0] rd_data_o  [NDUT];
    logic        rd_valid_o [NDUT];
    logic        busy_o     [NDUT];

    always #5 clk = ~clk;

    ram_sdp_be_clr #(
        .ADDR_WIDTH(6), .DATA_WIDTH(32), .DEPTH(64), .RDW_MODE(0), .CLEAR_VALUE(32'h0)
    ) dut_a (
        .clk(clk), .rst(rst), .clr(clr), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .wr_be(wr_be), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data_o[0]),
        .rd_valid(rd_valid_o[0]), .busy(busy_o[0])
    );

    ram_sdp_be_clr #(
        .ADDR_WIDTH(6), .DATA_WIDTH(32), .DEPTH(48), .RDW_MODE(1), .CLEAR_VALUE(32'h0000_00A5)
    ) dut_b (
        .clk(clk), .rst(rst), .clr(clr), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .wr_be(wr_be), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data_o[1]),
        .rd_valid(rd_valid_o[1]), .busy(busy_o[1])
    );

    function automatic int depth_of(input int k);
        return (k == 0) ? 64 : 48;
    endfunction

    function automatic logic [31:0] clear_of(input int k);
        return (k == 0) ? 32'h0 : 32'h0000_00A5;
    endfunction

    function automatic logic [31:0] merge_word(input logic [31:0] old_w, input logic [31:0] new_w,
                                               input logic [3:0] be);
        logic [31:0] mask;
        mask = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
        return (old_w & ~mask) | (new_w & mask);
    endfunction

    // Reference model state per instance; expected read words go through exp_q in instance order.
    logic [31:0] mem_m     [NDUT][64];
    bit          busy_m    [NDUT];
    int          ptr_m     [NDUT];
    logic [31:0] rd_data_m [NDUT];
    bit          exp_valid [NDUT];
    logic [31:0] exp_q [$];

    int n_compared   = 0;
    int n_mismatched = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_compared++;
        if (act !== exp) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic idle_inputs();
        rst = 1'b0; clr = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
        wr_addr = '0; rd_addr = '0; wr_data = '0; wr_be = '0;
    endtask

    task automatic checkOutput();
        logic [31:0] d;
        for (int k = 0; k < NDUT; k++) begin
            check(k == 0 ? "busy a" : "busy b", {31'b0, busy_o[k]}, {31'b0, busy_m[k]});
            check(k == 0 ? "rd_valid a" : "rd_valid b", {31'b0, rd_valid_o[k]}, {31'b0, exp_valid[k]});
            if (exp_valid[k]) begin
                d = exp_q.pop_front();
                rd_data_m[k] = d;
            end
            check(k == 0 ? "rd_data a" : "rd_data b", rd_data_o[k], rd_data_m[k]);
        end
    endtask

    // One clock: predict reads from the pre-edge model, clock, advance model, compare.
    task automatic applyStimulus();
        logic [31:0] d;
        for (int k = 0; k < NDUT; k++) begin
            exp_valid[k] = 1'b0;
            if (!rst && rd_en && !busy_m[k]) begin
                exp_valid[k] = 1'b1;
                if (int'(rd_addr) >= depth_of(k)) begin
                    d = '0;
                end else begin
                    d = mem_m[k][rd_addr];
                    if (k == 1 && wr_en && wr_addr == rd_addr) d = merge_word(d, wr_data, wr_be);
                end
                exp_q.push_back(d);
            end
        end
        @(posedge clk);
        #1;
        for (int k = 0; k < NDUT; k++) begin
            if (rst) begin
                busy_m[k] = 1'b1; ptr_m[k] = 0; rd_data_m[k] = '0;
            end else if (busy_m[k]) begin
                mem_m[k][ptr_m[k]] = clear_of(k);
                if (ptr_m[k] == depth_of(k) - 1) begin
                    busy_m[k] = 1'b0; ptr_m[k] = 0;
                end else begin
                    ptr_m[k]++;
                end
            end else begin
                if (wr_en && int'(wr_addr) < depth_of(k))
                    mem_m[k][wr_addr] = merge_word(mem_m[k][wr_addr], wr_data, wr_be);
                if (clr) begin
                    busy_m[k] = 1'b1; ptr_m[k] = 0;
                end
            end
        end
        checkOutput();
    endtask

    // Runs until both sweeps finish; counts busy cycles from the latest reset/clear edge.
    task automatic run_sweep(input int rst_at, input int clr_at, output int ca, output int cb);
        ca = int'(busy_o[0]);
        cb = int'(busy_o[1]);
        for (int i = 1; i < 300 && (busy_o[0] || busy_o[1]); i++) begin
            idle_inputs();
            rst = (i == rst_at);
            clr = (i == clr_at);
            if (i < 40 && i != rst_at) begin
                wr_en = 1'b1; wr_addr = 6'($urandom_range(0, 63)); wr_data = $urandom; wr_be = 4'hF;
                rd_en = 1'b1; rd_addr = 6'($urandom_range(0, 63));
            end
            applyStimulus();
            if (i == rst_at) begin
                ca = 0; cb = 0;
            end
            ca += int'(busy_o[0]);
            cb += int'(busy_o[1]);
            if (i < 40) begin
                check("rd_valid a during sweep", {31'b0, rd_valid_o[0]}, 32'h0);
                check("rd_valid b during sweep", {31'b0, rd_valid_o[1]}, 32'h0);
            end
        end
        idle_inputs();
    endtask

    task automatic read_all();
        for (int i = 0; i < 64; i++) begin
            idle_inputs();
            rd_en = 1'b1; rd_addr = 6'(i);
            applyStimulus();
            check("read_all a", rd_data_o[0], 32'h0);
            check("read_all b", rd_data_o[1], (i < 48) ? 32'h0000_00A5 : 32'h0);
        end
        idle_inputs();
    endtask

    typedef struct {
        logic        we;
        logic [5:0]  wa;
        logic [31:0] wd;
        logic [3:0]  be;
        logic        re;
        logic [5:0]  ra;
        logic [31:0] exp_a;
        logic [31:0] exp_b;
    } vec_t;

    vec_t vecs [$];

    task automatic add_vec(input logic we, input logic [5:0] wa, input logic [31:0] wd, input logic [3:0] be,
                           input logic re, input logic [5:0] ra, input logic [31:0] ea, input logic [31:0] eb);
        vec_t v;
        v.we = we; v.wa = wa; v.wd = wd; v.be = be; v.re = re; v.ra = ra; v.exp_a = ea; v.exp_b = eb;
        vecs.push_back(v);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int ca, cb;
        for (int k = 0; k < NDUT; k++) begin
            busy_m[k] = 1'b1; ptr_m[k] = 0; rd_data_m[k] = '0;
        end

        add_vec(1, 6'd5,  32'hAABBCCDD, 4'hF, 0, 6'd0,  32'h0,        32'h0);
        add_vec(1, 6'd5,  32'h11223344, 4'h5, 0, 6'd0,  32'h0,        32'h0);
        add_vec(0, 6'd0,  32'h0,        4'h0, 1, 6'd5,  32'hAA22CC44, 32'hAA22CC44);
        add_vec(1, 6'd9,  32'h0000005A, 4'hF, 1, 6'd9,  32'h0,        32'h0000005A);
        add_vec(0, 6'd0,  32'h0,        4'h0, 1, 6'd9,  32'h0000005A, 32'h0000005A);
        add_vec(1, 6'd47, 32'h12345678, 4'hF, 1, 6'd0,  32'h0,        32'h000000A5);
        add_vec(0, 6'd0,  32'h0,        4'h0, 1, 6'd47, 32'h12345678, 32'h12345678);
        add_vec(1, 6'd50, 32'hCAFEF00D, 4'hF, 1, 6'd50, 32'h0,        32'h0);
        add_vec(0, 6'd0,  32'h0,        4'h0, 1, 6'd50, 32'hCAFEF00D, 32'h0);
        add_vec(0, 6'd0,  32'h0,        4'h0, 1, 6'd18, 32'h0,        32'h000000A5);
        add_vec(0, 6'd0,  32'h0,        4'h0, 1, 6'd2,  32'h0,        32'h000000A5);
        add_vec(1, 6'd9,  32'hFFFFFFFF, 4'h0, 1, 6'd9,  32'h0000005A, 32'h0000005A);
        add_vec(0, 6'd0,  32'h0,        4'h0, 1, 6'd9,  32'h0000005A, 32'h0000005A);
        add_vec(1, 6'd20, 32'h0000BB00, 4'h2, 1, 6'd20, 32'h0,        32'h0000BBA5);
        add_vec(0, 6'd0,  32'h0,        4'h0, 1, 6'd20, 32'h0000BB00, 32'h0000BBA5);
        add_vec(1, 6'd63, 32'h0F0F0F0F, 4'hF, 1, 6'd47, 32'h12345678, 32'h12345678);
        add_vec(0, 6'd0,  32'h0,        4'h0, 1, 6'd63, 32'h0F0F0F0F, 32'h0);
        add_vec(0, 6'd0,  32'h0,        4'h0, 0, 6'd0,  32'h0,        32'h0);

        idle_inputs();
        rst = 1'b1;
        applyStimulus();
        rst = 1'b0;
        run_sweep(-1, -1, ca, cb);
        check("reset sweep length a", 32'(ca), 32'd64);
        check("reset sweep length b", 32'(cb), 32'd48);

        for (int i = 0; i < 3; i++) begin
            idle_inputs();
            rd_en = 1'b1;
            rd_addr = (i == 0) ? 6'd0 : (i == 1) ? 6'd31 : 6'd63;
            applyStimulus();
            check("post-reset read a", rd_data_o[0], 32'h0);
            check("post-reset valid a", {31'b0, rd_valid_o[0]}, 32'h1);
        end

        foreach (vecs[n]) begin
            idle_inputs();
            wr_en = vecs[n].we; wr_addr = vecs[n].wa; wr_data = vecs[n].wd; wr_be = vecs[n].be;
            rd_en = vecs[n].re; rd_addr = vecs[n].ra;
            applyStimulus();
            if (vecs[n].re) begin
                check("vector rd_data a", rd_data_o[0], vecs[n].exp_a);
                check("vector rd_data b", rd_data_o[1], vecs[n].exp_b);
            end else begin
                check("vector idle rd_valid a", {31'b0, rd_valid_o[0]}, 32'h0);
            end
        end

        for (int i = 0; i < 64; i++) begin
            idle_inputs();
            wr_en = 1'b1; wr_addr = 6'(i); wr_data = 32'(i); wr_be = 4'hF;
            applyStimulus();
        end
        for (int i = 0; i < 64; i++) begin
            idle_inputs();
            rd_en = 1'b1; rd_addr = 6'(i);
            applyStimulus();
            check("fill readback a", rd_data_o[0], 32'(i));
        end

        idle_inputs();
        wr_en = 1'b1; wr_addr = 6'd7; wr_data = 32'h7777_7777; wr_be = 4'hF; clr = 1'b1;
        applyStimulus();
        run_sweep(-1, -1, ca, cb);
        check("clear sweep length a", 32'(ca), 32'd64);
        check("clear sweep length b", 32'(cb), 32'd48);
        read_all();

        idle_inputs();
        clr = 1'b1;
        applyStimulus();
        run_sweep(20, 30, ca, cb);
        check("mid-sweep reset length a", 32'(ca), 32'd64);
        check("mid-sweep reset length b", 32'(cb), 32'd48);
        read_all();

        check("scoreboard drained", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule

// File: doc/ram_sdp_be_clr.md
Name: ram_sdp_be_clr

Overview:
Parametrised simple-dual-port synchronous RAM: one write port, one read port, single clock. Adds per-byte write enables, a registered read with valid flag, and a selectable read-during-write policy. A clear sequencer fills every word with a constant after reset or on command. Generic storage for buffers and lookup tables, replacing the fixed 64x8 single-port RAM.

Parameters:
ADDR_WIDTH, 6, address width in bits
DATA_WIDTH, 8, word width in bits; must be a multiple of 8
DEPTH, 64, number of words; must be <= 2**ADDR_WIDTH
RDW_MODE, 0, same-address read during write: 0 = return old data, 1 = return new data (bypass)
CLEAR_VALUE, 0, DATA_WIDTH-bit word written by the clear sweep

Ports:
clk  in  1  clock; all logic on the rising edge
rst  in  1  synchronous, active-high reset
clr  in  1  one-cycle pulse; starts a clear sweep
wr_en  in  1  write request
wr_addr  in  ADDR_WIDTH  write address
wr_data  in  DATA_WIDTH  write data
wr_be  in  DATA_WIDTH/8  byte enables; bit i covers wr_data[8i+7:8i]
rd_en  in  1  read request
rd_addr  in  ADDR_WIDTH  read address
rd_data  out  DATA_WIDTH  registered read data
rd_valid  out  1  high the cycle after an accepted read
busy  out  1  clear sweep in progress; requests are ignored

Behaviour:
- Reset: rd_data=0, rd_valid=0, busy=1. The FSM enters CLEAR with sweep pointer 0. Memory contents are undefined until the sweep completes.
- FSM states:
  - CLEAR: each cycle writes CLEAR_VALUE to mem[ptr] and increments ptr. When ptr==DEPTH-1 is written, the next state is IDLE and busy drops the following cycle.
  - IDLE: normal operation. clr=1 in IDLE moves the FSM to CLEAR with ptr=0 next cycle, and busy=1 from that cycle.
- Sweep length is exactly DEPTH cycles of busy=1.
- rst during CLEAR restarts the sweep at ptr 0.
- clr during CLEAR is ignored; the sweep does not restart.
- Requests while busy=1 have no effect:
  - wr_en: write dropped.
  - rd_en: rd_valid stays 0 and rd_data holds its value.
- Write (IDLE, wr_en=1, wr_addr<DEPTH): bytes with wr_be[i]=1 update at the clock edge; other bytes are unchanged. wr_be=0 is a no-op.
- Read (IDLE, rd_en=1): rd_data and rd_valid=1 appear one cycle later (latency 1).
- rd_en=0: rd_valid=0 next cycle and rd_data holds its previous value.
- Out of range:
  - wr_addr>=DEPTH: write dropped.
  - rd_addr>=DEPTH: rd_valid=1 with rd_data=0.
- Read during write, same address, same cycle:
  - RDW_MODE=0: rd_data is the pre-write word.
  - RDW_MODE=1: rd_data is the merged word (enabled bytes from wr_data, others from memory).
- Different addresses never interact.
- clr and wr_en in the same IDLE cycle: the write completes, then the sweep overwrites it.
- Storage is an unpacked reg array with no reset on contents; initialisation is only through the sweep.

Decomposition:
- Shared package ram_pkg:
  - FSM state enum (ST_IDLE, ST_CLEAR).
  - RDW_OLD/RDW_NEW constants.
  - Function nbytes(DATA_WIDTH) computing the byte-enable width.
- One natural sub-module, ram_clear_seq: FSM, sweep pointer and busy. It outputs a write override (addr, data, full enable) that the top muxes in front of the write port.
- Storage, byte merge and RDW logic stay in the top.

Test Plan:
1. Reset, defaults (DEPTH=64, DATA_WIDTH=8 unless noted): rst for 1 cycle -> busy=1 for exactly 64 cycles. Then reads of addresses 0, 31, 63 each give rd_data=0x00 with rd_valid=1 one cycle after rd_en.
2. Byte enables (DATA_WIDTH=32): write 0xAABBCCDD to addr 5 with be=4'hF, then 0x11223344 with be=4'b0101 -> read addr 5 returns 0xAA22CC44.
3. Read during write: write 0x5A over 0x00 at addr 9 with rd_en on addr 9 in the same cycle -> RDW_MODE=0 returns 0x00; RDW_MODE=1 returns 0x5A. A follow-up read returns 0x5A in both modes.
4. Command clear: fill addresses 0..63 with their index, pulse clr -> busy=1 for 64 cycles. wr_en and rd_en asserted during the sweep have no effect and rd_valid stays 0. Afterwards every address reads 0x00 (CLEAR_VALUE=0).
5. Reset mid-sweep: assert rst at sweep cycle 20 -> busy stays 1 for a further 64 cycles from the reset cycle, then all words equal CLEAR_VALUE. A clr pulse at cycle 30 of the sweep does not extend it.
6. Boundaries (DEPTH=48, ADDR_WIDTH=6):
   - write to addr 50 -> memory unchanged;
   - read of addr 50 -> rd_valid=1, rd_data=0;
   - write/read of addr 47 -> works normally.
